// File: rtl/mmips_dev_pkg.sv
// Shared definitions for the mMIPS device-port responder: state encoding,
// default widths and the saturating counter helper.
package mmips_dev_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_DEPTH_LOG2 = 3;
  localparam int STAT_W         = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_BODY = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_HDR  = S_HDR,
    ST_BODY = S_BODY
  } out_state_e;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dev_fifo.sv
// Synchronous show-ahead FIFO; rdata always presents the head entry.
// Pushes while full and pops while empty are ignored.
module dev_fifo #(
  parameter int W          = 33,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [W-1:0]        mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
  logic                do_push, do_pop;

  // The extra pointer bit distinguishes full (bits differ) from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[DEPTH_LOG2-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately left unreset; the pointers define which
  // entries are valid, and a resettable array would cost a flop per bit.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wdata;
  end

endmodule

// File: rtl/mmips_dev_handler.sv
// Device-side responder for the mMIPS dev_* port: RX FIFO toward the CPU,
// TX FIFO plus header/body framing toward the host. Packet counters exist
// only when DEV_STATS_EN is defined; otherwise stat_* are tied to 0.
module mmips_dev_handler
  import mmips_dev_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] dev_dout,
  input  logic              dev_w,
  input  logic              dev_waddr,
  input  logic              dev_wdata,
  input  logic              dev_send_eop,
  output logic              dev_rdyw,
  input  logic              dev_r,
  output logic [DATA_W-1:0] dev_din,
  output logic              dev_rdyr,
  output logic              dev_rcv_eop,
  input  logic              host_in_valid,
  output logic              host_in_ready,
  input  logic [DATA_W-1:0] host_in_data,
  input  logic              host_in_eop,
  output logic              host_out_valid,
  input  logic              host_out_ready,
  output logic [DATA_W-1:0] host_out_data,
  output logic              host_out_eop,
  output logic              host_out_hdr,
  output logic [STAT_W-1:0] stat_tx_pkts,
  output logic [STAT_W-1:0] stat_rx_pkts
);

  logic [DATA_W:0]   rx_head, tx_head;
  logic              rx_full, rx_empty, tx_full, tx_empty;
  logic              rx_push, rx_pop, tx_push, tx_pop;
  logic [DATA_W-1:0] addr_q, hdr_addr_q;
  out_state_e        state_q, state_d;

  // Ready flags are held low while reset is asserted.
  assign host_in_ready = !rx_full && !rst;
  assign rx_push       = host_in_valid && host_in_ready;
  assign dev_rdyr      = !rx_empty;
  assign rx_pop        = en && dev_r && dev_rdyr;
  assign dev_din       = rx_empty ? '0 : rx_head[DATA_W-1:0];
  assign dev_rcv_eop   = !rx_empty && rx_head[DATA_W];

  assign dev_rdyw = !tx_full && !rst;
  assign tx_push  = en && dev_w && dev_wdata && dev_rdyw;

  dev_fifo #(.W(DATA_W + 1), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .wdata({host_in_eop, host_in_data}),
    .pop(rx_pop), .rdata(rx_head), .full(rx_full), .empty(rx_empty)
  );

  dev_fifo #(.W(DATA_W + 1), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .wdata({dev_send_eop, dev_dout}),
    .pop(tx_pop), .rdata(tx_head), .full(tx_full), .empty(tx_empty)
  );

  // The header address is snapshotted on leaving IDLE so later address
  // writes only affect the following packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      hdr_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (en && dev_w && dev_waddr)          addr_q     <= dev_dout;
      if (state_q == ST_IDLE && !tx_empty)   hdr_addr_q <= addr_q;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    host_out_valid = 1'b0;
    host_out_hdr   = 1'b0;
    host_out_eop   = 1'b0;
    host_out_data  = '0;
    tx_pop         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!tx_empty) state_d = ST_HDR;
      end
      ST_HDR: begin
        host_out_valid = 1'b1;
        host_out_hdr   = 1'b1;
        host_out_data  = hdr_addr_q;
        if (host_out_ready) state_d = ST_BODY;
      end
      ST_BODY: begin
        host_out_valid = !tx_empty;
        if (!tx_empty) begin
          host_out_data = tx_head[DATA_W-1:0];
          host_out_eop  = tx_head[DATA_W];
        end
        tx_pop = host_out_ready && !tx_empty;
        if (tx_pop && tx_head[DATA_W]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef DEV_STATS_EN
  logic [STAT_W-1:0] tx_cnt_q, rx_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (tx_pop && tx_head[DATA_W]) tx_cnt_q <= sat_inc(tx_cnt_q);
      if (rx_pop && rx_head[DATA_W]) rx_cnt_q <= sat_inc(rx_cnt_q);
    end
  end

  assign stat_tx_pkts = tx_cnt_q;
  assign stat_rx_pkts = rx_cnt_q;
`else
  assign stat_tx_pkts = '0;
  assign stat_rx_pkts = '0;
`endif

endmodule

// File: tb/tb_mmips_dev_handler.sv
// Self-checking bench for mmips_dev_handler: directed scenarios plus random
// traffic, scored against queue-based models of the RX path and packet stream.
module tb_mmips_dev_handler;
  import mmips_dev_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en, dev_w, dev_waddr, dev_wdata, dev_send_eop, dev_r;
  logic [DW-1:0] dev_dout, dev_din, host_in_data, host_out_data;
  logic          dev_rdyw, dev_rdyr, dev_rcv_eop;
  logic          host_in_valid, host_in_ready, host_in_eop;
  logic          host_out_valid, host_out_ready, host_out_eop, host_out_hdr;
  logic [15:0]   stat_tx_pkts, stat_rx_pkts;

  always #5 clk = ~clk;

  mmips_dev_handler dut (
    .clk(clk), .rst(rst), .en(en), .dev_dout(dev_dout), .dev_w(dev_w),
    .dev_waddr(dev_waddr), .dev_wdata(dev_wdata), .dev_send_eop(dev_send_eop),
    .dev_rdyw(dev_rdyw), .dev_r(dev_r), .dev_din(dev_din), .dev_rdyr(dev_rdyr),
    .dev_rcv_eop(dev_rcv_eop), .host_in_valid(host_in_valid),
    .host_in_ready(host_in_ready), .host_in_data(host_in_data),
    .host_in_eop(host_in_eop), .host_out_valid(host_out_valid),
    .host_out_ready(host_out_ready), .host_out_data(host_out_data),
    .host_out_eop(host_out_eop), .host_out_hdr(host_out_hdr),
    .stat_tx_pkts(stat_tx_pkts), .stat_rx_pkts(stat_rx_pkts)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  typedef struct packed {
    logic          eop;
    logic [DW-1:0] data;
  } word_t;

  word_t         rx_q[$];
  word_t         tx_q[$];
  logic [DW-1:0] hdr_q[$];
  logic [DW-1:0] cur_addr = '0;
  bit            pkt_start = 1'b1;
  bit            expect_hdr = 1'b1;
  int            tx_pkts = 0, rx_pkts = 0;
  bit            pv = 1'b0, pr = 1'b0, phdr = 1'b0, peop = 1'b0;
  logic [DW-1:0] pdata = '0;

  task automatic model_clear();
    rx_q.delete(); tx_q.delete(); hdr_q.delete();
    cur_addr = '0; pkt_start = 1'b1; expect_hdr = 1'b1;
    tx_pkts = 0; rx_pkts = 0; pv = 1'b0;
  endtask

  // Compare outputs with the model, then advance the model by the inputs
  // being applied in this cycle.
  task automatic monitor();
    word_t w;
    bit rx_ok, tx_ok;
    rx_ok = rx_q.size() < DEPTH;
    tx_ok = tx_q.size() < DEPTH;
    check("dev_rdyr", 64'(dev_rdyr), 64'(rx_q.size() != 0));
    if (rx_q.size() != 0) begin
      check("dev_din", 64'(dev_din), 64'(rx_q[0].data));
      check("dev_rcv_eop", 64'(dev_rcv_eop), 64'(rx_q[0].eop));
    end
    check("host_in_ready", 64'(host_in_ready), 64'(rx_ok));
    check("dev_rdyw", 64'(dev_rdyw), 64'(tx_ok));
    if (pv && !pr) begin
      check("hold_valid", 64'(host_out_valid), 64'(1));
      check("hold_data", 64'(host_out_data), 64'(pdata));
      check("hold_hdr", 64'(host_out_hdr), 64'(phdr));
      check("hold_eop", 64'(host_out_eop), 64'(peop));
    end
    pv = host_out_valid; pr = host_out_ready;
    pdata = host_out_data; phdr = host_out_hdr; peop = host_out_eop;

    if (host_out_valid && host_out_ready) begin
      if (expect_hdr) begin
        check("out_is_hdr", 64'(host_out_hdr), 64'(1));
        if (hdr_q.size() == 0) check("spurious_hdr", 64'(host_out_valid), 64'(0));
        else begin
          check("hdr_addr", 64'(host_out_data), 64'(hdr_q.pop_front()));
          expect_hdr = 1'b0;
        end
      end else begin
        check("out_is_body", 64'(host_out_hdr), 64'(0));
        if (tx_q.size() == 0) check("spurious_word", 64'(host_out_valid), 64'(0));
        else begin
          w = tx_q.pop_front();
          check("body_data", 64'(host_out_data), 64'(w.data));
          check("body_eop", 64'(host_out_eop), 64'(w.eop));
          if (w.eop) begin
            expect_hdr = 1'b1;
            tx_pkts++;
          end
        end
      end
    end

    if (en && dev_r && rx_q.size() != 0) begin
      w = rx_q.pop_front();
      if (w.eop) rx_pkts++;
    end
    if (host_in_valid && rx_ok) rx_q.push_back('{eop: host_in_eop, data: host_in_data});
    if (en && dev_w && dev_waddr) cur_addr = dev_dout;
    if (en && dev_w && dev_wdata && tx_ok) begin
      if (pkt_start) hdr_q.push_back(cur_addr);
      pkt_start = dev_send_eop;
      tx_q.push_back('{eop: dev_send_eop, data: dev_dout});
    end
  endtask

  // Inputs are set at the falling edge; the model advances with them.
  task automatic tick();
    monitor();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    en = 1'b1; dev_w = 1'b0; dev_waddr = 1'b0; dev_wdata = 1'b0;
    dev_send_eop = 1'b0; dev_dout = '0; dev_r = 1'b0;
    host_in_valid = 1'b0; host_in_data = '0; host_in_eop = 1'b0;
  endtask

  task automatic cpu_write(input bit a, input bit d, input bit eop, input logic [DW-1:0] v);
    en = 1'b1; dev_w = 1'b1; dev_waddr = a; dev_wdata = d;
    dev_send_eop = eop; dev_dout = v;
    tick();
    dev_w = 1'b0; dev_waddr = 1'b0; dev_wdata = 1'b0; dev_send_eop = 1'b0;
  endtask

  // mode 0: ready high, 1: ready toggles every cycle, 2: random ready
  task automatic drain(input int mode);
    idle_inputs();
    host_out_ready = 1'b1;
    for (int i = 0; i < 400 && (tx_q.size() != 0 || hdr_q.size() != 0); i++) begin
      if (mode == 1) host_out_ready = ~host_out_ready;
      else if (mode == 2) host_out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    check("drain_tx_words", 64'(tx_q.size()), 64'(0));
    check("drain_headers", 64'(hdr_q.size()), 64'(0));
    host_out_ready = 1'b1;
    tick();
    tick();
    check("idle_after_pkt", 64'(host_out_valid), 64'(0));
  endtask

  task automatic check_stats(input string tag);
    logic [15:0] exp_tx, exp_rx;
`ifdef DEV_STATS_EN
    exp_tx = (tx_pkts > 65535) ? 16'hFFFF : 16'(tx_pkts);
    exp_rx = (rx_pkts > 65535) ? 16'hFFFF : 16'(rx_pkts);
`else
    exp_tx = '0;
    exp_rx = '0;
`endif
    check({tag, "_stat_tx"}, 64'(stat_tx_pkts), 64'(exp_tx));
    check({tag, "_stat_rx"}, 64'(stat_rx_pkts), 64'(exp_rx));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, k, guard;
    bit combined;
    logic [DW-1:0] addr;

    rst = 1'b1;
    host_out_ready = 1'b0;
    idle_inputs();
    @(negedge clk);
    check("rst_valid", 64'(host_out_valid), 64'(0));
    check("rst_data", 64'(host_out_data), 64'(0));
    check("rst_hdr", 64'(host_out_hdr), 64'(0));
    check("rst_rdyr", 64'(dev_rdyr), 64'(0));
    check("rst_din", 64'(dev_din), 64'(0));
    check("rst_stat_tx", 64'(stat_tx_pkts), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    tick();

    // RX path: two host words, then pops including one on empty.
    host_in_valid = 1'b1; host_in_data = 32'h11; host_in_eop = 1'b0;
    tick();
    host_in_data = 32'h22; host_in_eop = 1'b1;
    tick();
    host_in_valid = 1'b0;
    dev_r = 1'b1;
    repeat (3) tick();
    dev_r = 1'b0;
    tick();

    // Basic packet with latency checks.
    host_out_ready = 1'b1;
    cpu_write(1'b1, 1'b0, 1'b0, 32'h8000);
    cpu_write(1'b0, 1'b1, 1'b0, 32'hA);
    check("lat_idle_cycle", 64'(host_out_valid), 64'(0));
    cpu_write(1'b0, 1'b1, 1'b1, 32'hB);
    check("lat_hdr_valid", 64'(host_out_valid), 64'(1));
    check("lat_hdr_flag", 64'(host_out_hdr), 64'(1));
    drain(0);

    // Fill TX with the host stalled, then a dropped ninth write.
    host_out_ready = 1'b0;
    cpu_write(1'b1, 1'b0, 1'b0, 32'h1234);
    for (int i = 0; i < 8; i++) cpu_write(1'b0, 1'b1, (i == 7), 32'h100 + 32'(i));
    check("full_rdyw", 64'(dev_rdyw), 64'(0));
    cpu_write(1'b0, 1'b1, 1'b1, 32'hDEAD);
    drain(0);

    // Backpressure: ready toggles every cycle.
    cpu_write(1'b1, 1'b0, 1'b0, 32'h5555);
    for (int i = 0; i < 5; i++) cpu_write(1'b0, 1'b1, (i == 4), $urandom);
    drain(1);

    // Address writes during HDR and BODY only affect the next packet.
    host_out_ready = 1'b0;
    cpu_write(1'b1, 1'b0, 1'b0, 32'hA000);
    for (int i = 0; i < 3; i++) cpu_write(1'b0, 1'b1, (i == 2), 32'h200 + 32'(i));
    cpu_write(1'b1, 1'b0, 1'b0, 32'hB000);
    host_out_ready = 1'b1;
    tick();
    cpu_write(1'b1, 1'b0, 1'b0, 32'hC000);
    cpu_write(1'b0, 1'b1, 1'b0, 32'h300);
    cpu_write(1'b0, 1'b1, 1'b1, 32'h301);
    drain(0);
    check_stats("directed");

    // Random traffic on both directions.
    for (int p = 0; p < 20; p++) begin
      len = $urandom_range(1, 10);
      addr = $urandom;
      combined = $urandom_range(0, 1) == 1;
      if (!combined) cpu_write(1'b1, 1'b0, 1'b0, addr);
      k = 0;
      guard = 0;
      while (k < len && guard < 400) begin
        guard++;
        host_out_ready = ($urandom_range(0, 3) != 0);
        en            = ($urandom_range(0, 7) != 0);
        host_in_valid = $urandom_range(0, 1) == 1;
        host_in_data  = $urandom;
        host_in_eop   = ($urandom_range(0, 3) == 0);
        dev_r         = $urandom_range(0, 1) == 1;
        dev_w         = $urandom_range(0, 1) == 1;
        dev_wdata     = 1'b1;
        dev_waddr     = combined && (k == 0);
        dev_dout      = (combined && k == 0) ? addr : $urandom;
        dev_send_eop  = (k == len - 1);
        if (en && dev_w && tx_q.size() < DEPTH) k++;
        tick();
      end
      check("rand_write_budget", 64'(k), 64'(len));
      drain(2);
    end
    en = 1'b1;
    dev_r = 1'b1;
    repeat (DEPTH + 2) tick();
    dev_r = 1'b0;
    tick();
    check_stats("random");

    // Reset while a packet is mid-body with three words queued.
    host_out_ready = 1'b0;
    host_in_valid = 1'b1; host_in_data = 32'h77; host_in_eop = 1'b1;
    tick();
    host_in_valid = 1'b0;
    cpu_write(1'b1, 1'b0, 1'b0, 32'h7777);
    for (int i = 0; i < 3; i++) cpu_write(1'b0, 1'b1, (i == 2), 32'h400 + 32'(i));
    host_out_ready = 1'b1;
    tick();
    host_out_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(host_out_valid), 64'(0));
    check("mid_rst_data", 64'(host_out_data), 64'(0));
    check("mid_rst_eop", 64'(host_out_eop), 64'(0));
    check("mid_rst_rdyr", 64'(dev_rdyr), 64'(0));
    check("mid_rst_din", 64'(dev_din), 64'(0));
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    host_out_ready = 1'b1;
    idle_inputs();
    repeat (10) tick();
    check("post_rst_valid", 64'(host_out_valid), 64'(0));
    check("post_rst_rdyw", 64'(dev_rdyw), 64'(1));
    check_stats("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
